zamanlayici: RTL and testbench

Memory-mapped, read-only machine timer on the load path, directly downstream of the address decoder's timer select (address bits 30:28 == 3, reads only). It holds a 64-bit free-running tick counter behind a clock prescaler and returns registered 32-bit read data one cycle after each select. An optional periodic tick flag can be compiled in as an interrupt source.

---
 rtl/zamanlayici_pkg.sv | 19 +
 rtl/zamanlayici_on_olcekleyici.sv | 38 +++
 rtl/zamanlayici.sv | 127 ++++++++++++
 tb/tb_zamanlayici.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/zamanlayici_pkg.sv
// rtl/zamanlayici_pkg.sv - shared constants for the machine timer and its address decoder
//
// Purpose: register offsets selected by adres_i[3:2] and the decoder region
// code (address bits 30:28) that routes loads to the timer.
// Ports: none (package).
package zamanlayici_pkg;

  // Register offsets, indexed by load address bits [3:2].
  typedef enum logic [1:0] {
    ZMN_SAYAC_ALT = 2'd0,  // sayac[31:0], also snapshots sayac[63:32]
    ZMN_SAYAC_UST = 2'd1,  // snapshot taken by the last low-word read
    ZMN_DURUM     = 2'd2,  // bit0 = periodic flag, read-to-clear
    ZMN_DONEM     = 2'd3   // PERIOD constant
  } zmn_adres_e;

  // Region code for address bits 30:28 that selects the timer.
  localparam logic [2:0] ZMN_BOLGE_ZAMANLAYICI = 3'd3;

endpackage

// File: rtl/zamanlayici_on_olcekleyici.sv
// rtl/zamanlayici_on_olcekleyici.sv - clock prescaler producing the timer tick
//
// Purpose: olcek counts 0..PRESCALE-1; tik_o is high in the cycle where
// olcek == PRESCALE-1, after which olcek returns to 0.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-low reset
//   tik_o  one-cycle tick strobe (constant 1 when PRESCALE == 1)
module on_olcekleyici #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tik_o
);

  localparam int unsigned OW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [OW-1:0] OLCEK_SON = OW'(PRESCALE - 1);

  logic [OW-1:0] olcek_q;
  logic [OW-1:0] olcek_d;

  // With PRESCALE == 1 the counter sits at 0 == OLCEK_SON, so tik_o is
  // permanently high without needing a separate code path.
  always_comb begin
    tik_o   = (olcek_q == OLCEK_SON);
    olcek_d = tik_o ? '0 : olcek_q + OW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      olcek_q <= '0;
    end else begin
      olcek_q <= olcek_d;
    end
  end

endmodule

// File: rtl/zamanlayici.sv
// rtl/zamanlayici.sv - read-only memory-mapped 64-bit machine timer
//
// Purpose: 64-bit free-running tick counter behind a prescaler, with a
// coherent high-word snapshot and registered 32-bit read data one cycle
// after each select. Optional periodic flag built when ZAMANLAYICI_KESME_EN
// is defined; otherwise the status register reads 0 and kesme_o is 0.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-low reset
//   timer_i    read select from the address decoder (one read per high cycle)
//   adres_i    load address bits [3:2], register select
//   veri_o     registered read data, holds when no read
//   gecerli_o  one-cycle valid strobe for veri_o
//   kesme_o    periodic-event flag (level)
module zamanlayici
  import zamanlayici_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PERIOD   = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        timer_i,
  input  logic [1:0]  adres_i,
  output logic [31:0] veri_o,
  output logic        gecerli_o,
  output logic        kesme_o
);

  logic        tik;
  logic [63:0] sayac_q, sayac_d;
  logic [31:0] ust_kopya_q, ust_kopya_d;
  logic [31:0] veri_q, veri_d;
  logic        gecerli_q;
  logic [31:0] durum;
  logic [31:0] oku_veri;
  logic        durum_oku;

  on_olcekleyici #(
    .PRESCALE (PRESCALE)
  ) u_on_olcekleyici (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tik_o (tik)
  );

  assign durum_oku = timer_i && (adres_i == ZMN_DURUM);

`ifdef ZAMANLAYICI_KESME_EN
  localparam int unsigned DW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DW-1:0] DONEM_SON = DW'(PERIOD - 1);

  logic [DW-1:0] donem_q, donem_d;
  logic          bayrak_q, bayrak_d;
  logic          olay;

  // A new event wins over a coinciding read-clear; the read itself still
  // sees the pre-edge flag through the read mux.
  always_comb begin
    olay     = tik && (donem_q == DONEM_SON);
    donem_d  = donem_q;
    if (tik) begin
      donem_d = olay ? '0 : donem_q + DW'(1);
    end
    bayrak_d = bayrak_q;
    if (durum_oku) begin
      bayrak_d = 1'b0;
    end
    if (olay) begin
      bayrak_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      donem_q  <= '0;
      bayrak_q <= 1'b0;
    end else begin
      donem_q  <= donem_d;
      bayrak_q <= bayrak_d;
    end
  end

  assign durum   = {31'b0, bayrak_q};
  assign kesme_o = bayrak_q;
`else
  assign durum   = 32'b0;
  assign kesme_o = 1'b0;
`endif

  // All read sources are pre-edge values, so a low-word read in a tick
  // cycle returns the count before that increment.
  always_comb begin
    case (adres_i)
      ZMN_SAYAC_ALT: oku_veri = sayac_q[31:0];
      ZMN_SAYAC_UST: oku_veri = ust_kopya_q;
      ZMN_DURUM:     oku_veri = durum;
      default:       oku_veri = 32'(PERIOD);
    endcase
  end

  always_comb begin
    sayac_d     = tik ? sayac_q + 64'd1 : sayac_q;
    // Snapshot the high word alongside the low-word read so a low-then-high
    // pair is coherent even if the low word wraps in between.
    ust_kopya_d = (timer_i && (adres_i == ZMN_SAYAC_ALT)) ? sayac_q[63:32] : ust_kopya_q;
    veri_d      = timer_i ? oku_veri : veri_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac_q     <= '0;
      ust_kopya_q <= '0;
      veri_q      <= '0;
      gecerli_q   <= 1'b0;
    end else begin
      sayac_q     <= sayac_d;
      ust_kopya_q <= ust_kopya_d;
      veri_q      <= veri_d;
      gecerli_q   <= timer_i;
    end
  end

  assign veri_o    = veri_q;
  assign gecerli_o = gecerli_q;

endmodule

// File: tb/tb_zamanlayici.sv
// tb/tb_zamanlayici.sv - self-checking bench for zamanlayici (PRESCALE 1 and 4)
module tb_zamanlayici;

  logic        clk;
  logic        rst_i;
  logic        timer1, timer4;
  logic [1:0]  adres1, adres4;
  logic [31:0] veri1, veri4;
  logic        gecerli1, gecerli4;
  logic        kesme1, kesme4;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Reference state: edges since reset release, last status-read edge,
  // modelled high-word snapshot and last returned data per instance.
  longint unsigned edges;
  longint unsigned clr_m [2];
  logic [31:0]     ust_m [2];
  logic [31:0]     veri_m [2];

  zamanlayici #(.PRESCALE(1), .PERIOD(5)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .timer_i(timer1), .adres_i(adres1),
    .veri_o(veri1), .gecerli_o(gecerli1), .kesme_o(kesme1)
  );

  zamanlayici #(.PRESCALE(4), .PERIOD(3)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .timer_i(timer4), .adres_i(adres4),
    .veri_o(veri4), .gecerli_o(gecerli4), .kesme_o(kesme4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edges);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic longint unsigned prs(input int i);
    return (i == 0) ? 64'd1 : 64'd4;
  endfunction

  function automatic longint unsigned per(input int i);
    return (i == 0) ? 64'd5 : 64'd3;
  endfunction

  // Counter value after e edges: one tick per PRESCALE edges.
  function automatic longint unsigned sayac_m(input int i, input longint unsigned e);
    return e / prs(i);
  endfunction

  // Flag after edge e: set if some event edge (a multiple of PRESCALE*PERIOD)
  // lies at or after the last clearing read; an event on the clearing edge wins.
  function automatic bit flag_m(input int i, input longint unsigned e);
`ifdef ZAMANLAYICI_KESME_EN
    longint unsigned pp;
    longint unsigned k;
    pp = prs(i) * per(i);
    k  = (e / pp) * pp;
    return (k != 0) && (k >= clr_m[i]);
`else
    return (i < 0) && (e == 0);
`endif
  endfunction

  task automatic model_read(input int i, input bit t, input logic [1:0] a);
    longint unsigned s;
    if (!t) return;
    s = sayac_m(i, edges - 1);
    case (a)
      2'd0: begin
        veri_m[i] = s[31:0];
        ust_m[i]  = s[63:32];
      end
      2'd1: veri_m[i] = ust_m[i];
      2'd2: begin
        veri_m[i] = {31'b0, flag_m(i, edges - 1)};
        clr_m[i]  = edges;
      end
      default: veri_m[i] = per(i)[31:0];
    endcase
  endtask

  task automatic model_reset();
    edges = 0;
    for (int i = 0; i < 2; i++) begin
      clr_m[i]  = 0;
      ust_m[i]  = '0;
      veri_m[i] = '0;
    end
  endtask

  task automatic cycle(input bit t1, input logic [1:0] a1, input bit t4, input logic [1:0] a4);
    timer1 = t1; adres1 = a1;
    timer4 = t4; adres4 = a4;
    @(posedge clk);
    edges++;
    model_read(0, t1, a1);
    model_read(1, t4, a4);
    #1;
    chk("gecerli1", 64'(gecerli1), 64'(t1));
    chk("veri1",    64'(veri1),    64'(veri_m[0]));
    chk("kesme1",   64'(kesme1),   64'(flag_m(0, edges)));
    chk("gecerli4", 64'(gecerli4), 64'(t4));
    chk("veri4",    64'(veri4),    64'(veri_m[1]));
    chk("kesme4",   64'(kesme4),   64'(flag_m(1, edges)));
  endtask

  initial begin
    rst_i = 1'b0;
    timer1 = 1'b0; adres1 = 2'd0;
    timer4 = 1'b0; adres4 = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_veri1",    64'(veri1),    64'd0);
    chk("rst_gecerli1", 64'(gecerli1), 64'd0);
    chk("rst_kesme1",   64'(kesme1),   64'd0);
    chk("rst_veri4",    64'(veri4),    64'd0);
    chk("rst_gecerli4", 64'(gecerli4), 64'd0);
    rst_i = 1'b1;

    // Directed: idle 10 edges, then reads and flag corner cases.
    for (int n = 0; n < 10; n++) cycle(0, 0, 0, 0);
    cycle(1, 2'd0, 0, 0);
    chk("p1_sayac10", 64'(veri1), 64'd10);
    cycle(1, 2'd1, 0, 0);
    chk("p1_ust0", 64'(veri1), 64'd0);
    cycle(1, 2'd2, 0, 0);
`ifdef ZAMANLAYICI_KESME_EN
    chk("durum_set", 64'(veri1), 64'd1);
`else
    chk("durum_off", 64'(veri1), 64'd0);
`endif
    cycle(1, 2'd2, 0, 0);
    chk("durum_clr", 64'(veri1), 64'd0);
    cycle(1, 2'd2, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 2'd3, 1, 2'd0);
    chk("p4_sayac4", 64'(veri4), 64'd4);
    chk("donem5",    64'(veri1), 64'd5);
    cycle(0, 0, 0, 0);
    cycle(1, 2'd2, 0, 0);
`ifdef ZAMANLAYICI_KESME_EN
    chk("esz_veri",  64'(veri1),  64'd1);
    chk("esz_kesme", 64'(kesme1), 64'd1);
`else
    chk("esz_kesme", 64'(kesme1), 64'd0);
`endif

    // Randomized reads on both instances with occasional idle stretches.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 8)) cycle(0, 0, 0, 0);
      end
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    // Reset mid-operation: completed read is cleared, in-flight read dropped.
    cycle(1, 2'd0, 0, 0);
    chk("pre_rst_gecerli", 64'(gecerli1), 64'd1);
    rst_i = 1'b0;
    #1;
    chk("async_veri1",    64'(veri1),    64'd0);
    chk("async_gecerli1", 64'(gecerli1), 64'd0);
    chk("async_kesme1",   64'(kesme1),   64'd0);
    @(posedge clk);
    #1;
    chk("drop_gecerli1", 64'(gecerli1), 64'd0);
    rst_i = 1'b1;
    model_reset();
    cycle(1, 2'd0, 1, 2'd0);
    chk("post_rst_sayac1", 64'(veri1), 64'd0);
    chk("post_rst_sayac4", 64'(veri4), 64'd0);

    // Coherent 64-bit read across a low-word wrap.
    timer1 = 1'b1; adres1 = 2'd0;
    timer4 = 1'b0;
    force dut1.sayac_q = 64'h0000_0000_FFFF_FFFF;
    #2;
    release dut1.sayac_q;
    @(posedge clk);
    #1;
    chk("koh_alt", 64'(veri1), 64'h0000_0000_FFFF_FFFF);
    adres1 = 2'd1;
    @(posedge clk);
    #1;
    chk("koh_ust", 64'(veri1), 64'd0);
    adres1 = 2'd0;
    @(posedge clk);
    #1;
    chk("koh_alt2", 64'(veri1), 64'd1);
    adres1 = 2'd1;
    @(posedge clk);
    #1;
    chk("koh_ust2", 64'(veri1), 64'd1);
    timer1 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
